// File: rtl/pipe_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seg_pkg
// Brief    : Shared state encoding, default widths and saturation helper for
//            the pipeline segment buffer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_seg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } seg_state_t;

   localparam int DEF_DW    = 32;
   localparam int DEF_CNT_W = 16;

   // All-ones value of a w-bit counter (w <= 64); the shift wraps cleanly at 64.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_seg_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seg_sat_cnt
// Brief    : W-bit counter that increments on inc, sticks at all-ones and
//            clears synchronously on clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_seg_sat_cnt
   import pipe_seg_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [63:0] MAX64 = sat_max(W);
   localparam logic [W-1:0] MAX  = MAX64[W-1:0];

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_seg_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seg_buf
// Brief    : Two-entry valid/ready skid buffer between pipeline stages with
//            flush support. Optional statistics enabled by PIPE_SEG_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_seg_buf
   import pipe_seg_pkg::*;
#(
   parameter int DW = DEF_DW
`ifdef PIPE_SEG_STAT_EN
  ,parameter int CNT_W = DEF_CNT_W
`endif
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          refresh,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
`ifdef PIPE_SEG_STAT_EN
  ,output logic [CNT_W-1:0] stat_stall_cnt
  ,output logic [CNT_W-1:0] stat_flush_cnt
`endif
);

   seg_state_t    state, state_nxt;
   logic [DW-1:0] m_q, m_nxt;
   logic [DW-1:0] s_q, s_nxt;
   logic          in_fire, out_fire;

   // Handshake outputs come from registered state only; resetn gating aside,
   // downstream backpressure never reaches upstream in the same cycle.
   assign in_ready  = resetn & (state != SKID);
   assign out_valid = (state != EMPTY);
   assign out_data  = m_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      m_nxt     = m_q;
      s_nxt     = s_q;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt = FULL;
               m_nxt     = in_data;
            end
         end
         FULL: begin
            if (in_fire && out_fire) begin
               m_nxt = in_data;
            end else if (in_fire) begin
               state_nxt = SKID;
               s_nxt     = in_data;
            end else if (out_fire) begin
               // M keeps its stale payload; out_valid alone marks it dead.
               state_nxt = EMPTY;
            end
         end
         SKID: begin
            if (out_fire) begin
               state_nxt = FULL;
               m_nxt     = s_q;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn || refresh) begin
         state <= EMPTY;
         m_q   <= '0;
         s_q   <= '0;
      end else begin
         state <= state_nxt;
         m_q   <= m_nxt;
         s_q   <= s_nxt;
      end
   end

`ifdef PIPE_SEG_STAT_EN
   // Refresh does not clear the statistics; only reset does.
   pipe_seg_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (!resetn),
      .inc   (out_valid & !out_ready),
      .cnt   (stat_stall_cnt)
   );

   pipe_seg_sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (!resetn),
      .inc   (refresh & (state != EMPTY)),
      .cnt   (stat_flush_cnt)
   );
`endif

endmodule
`default_nettype wire

// File: doc/pipe_seg_buf.md
Name: pipe_seg_buf

Overview:
- Parametrised, handshaked successor to the fixed stage-to-stage pipeline registers between EX, MEM and WB.
- Carries an opaque DW-bit payload (pc, inst, result, control bits packed by the instantiating stage) under valid/ready flow control.
- A two-entry skid buffer keeps in_ready a function of state only, so backpressure never forms a combinational path upstream.
- Supports refresh (flush) for exceptions and eret.

Parameters:
- DW, 32, payload width in bits (>=1).
- CNT_W, 16, statistic counter width; used only with PIPE_SEG_STAT_EN.

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  synchronous active-low reset.
- refresh  in  1  flush; discards all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer accepts entry this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts entry (inverse of a stall).
- out_data  out  DW  downstream payload.
- stat_stall_cnt  out  CNT_W  present only with PIPE_SEG_STAT_EN.
- stat_flush_cnt  out  CNT_W  present only with PIPE_SEG_STAT_EN.

Behaviour:
- Interface: one clock clk; reset resetn is synchronous, active-low.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register M (drives out_data) and skid register S.
- State encoding, 2 bits: EMPTY, FULL (M valid), SKID (M and S valid).
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = resetn & (state != SKID).
  - Both are decoded from registered state only; no in->out combinational path except the resetn gating.
- Reset, resetn=0 at posedge: state=EMPTY, M=0, S=0. Outputs while resetn is low: out_valid=0, in_ready=0, out_data=0.
- Refresh, refresh=1 at posedge and resetn=1:
  - state=EMPTY, M=0, S=0.
  - Any in_fire or out_fire in that cycle is dropped. The entry is not stored, and the downstream consumer must also ignore it, since refresh is broadcast to all stages.
  - Refresh beats every other event; reset beats refresh.
- Transitions, applied when not reset and not refreshing:
  - EMPTY: in_fire -> FULL, M<=in_data. Otherwise stay EMPTY.
  - FULL, in_fire & out_fire -> FULL, M<=in_data. This gives back-to-back throughput of 1 per cycle.
  - FULL, in_fire & !out_fire -> SKID, S<=in_data, M held.
  - FULL, !in_fire & out_fire -> EMPTY. M holds its stale value, which is not cleared.
  - FULL, neither -> hold.
  - SKID: out_fire -> FULL, M<=S. in_fire is impossible (in_ready=0). Otherwise hold.
- Latency: 1 cycle from in_fire into EMPTY or FULL-with-drain to out_valid.
- Ordering: strict FIFO, depth 2. No entry is duplicated or lost except by refresh or reset.
- out_data is stable while out_valid & !out_ready; in_ready never depends on out_ready in the same cycle.
- in_valid=0 with in_data changing: no effect.

Optional Feature:
- Macro: PIPE_SEG_STAT_EN.
- Defined:
  - stat_stall_cnt increments each cycle with out_valid & !out_ready.
  - stat_flush_cnt increments each cycle with refresh=1 and state != EMPTY.
  - Both counters saturate at all-ones, clear on reset, and are not cleared by refresh.
- Undefined: the counters and the two stat ports do not exist; core behaviour is identical.

Decomposition:
- Package pipe_seg_pkg holds:
  - state encoding constants (EMPTY=2'd0, FULL=2'd1, SKID=2'd2);
  - default DW and CNT_W;
  - a helper constant for the saturation value.
- Optional sub-module pipe_seg_sat_cnt: a CNT_W-wide saturating counter with inc/clear, instantiated twice under PIPE_SEG_STAT_EN.
- The core FSM and registers stay in pipe_seg_buf.

Test Plan:
- Reset with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, in_ready=0, out_data=0. After release: in_ready=1, state EMPTY.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the three following cycles, in_ready constant 1.
- Stall: push 0xA then 0xB with out_ready=0 -> in_ready drops to 0 after the second accept, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1 in the cycle after 0xA leaves.
- Refresh in SKID state (0xA, 0xB held) with in_valid=1, out_ready=1 -> next cycle out_valid=0, out_data=0, in_ready=1; 0xA, 0xB and the offered entry are never delivered.
- Refresh asserted together with resetn=0 -> reset values; refresh with state EMPTY and in_valid=1 -> entry dropped, stays EMPTY.
- PIPE_SEG_STAT_EN with CNT_W=4: hold out_valid & !out_ready for 20 cycles -> stat_stall_cnt=15 (saturated). Refresh from FULL -> stat_flush_cnt=1; refresh from EMPTY -> unchanged.
